// File: rtl/color_lookup_if.sv
// color_lookup_if: pixel input, color RAM video port and RGB output bundle
interface color_lookup_if;
  logic       pix_valid;
  logic [7:0] pix_index;
  logic       hblank;
  logic       vblank;
  logic [7:0] ram_a;
  logic       ram_r_n;
  logic [7:0] ram_do;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       out_valid;
  logic       out_hblank;
  logic       out_vblank;
  modport master (
    output pix_valid, pix_index, hblank, vblank, ram_do,
    input  ram_a, ram_r_n, red, green, blue, out_valid, out_hblank, out_vblank
  );
  modport slave (
    input  pix_valid, pix_index, hblank, vblank, ram_do,
    output ram_a, ram_r_n, red, green, blue, out_valid, out_hblank, out_vblank
  );
endinterface

// File: rtl/color_lookup.sv
// color_lookup: 3-stage palette lookup from color RAM to 4-bit RGB, fixed latency 3
module color_lookup #(
  parameter bit INVERT = 1'b0
) (
  input logic          clk,
  input logic          reset_n,
  color_lookup_if.slave bus
);
  logic       va, ha, vba, vb, hb, vbb;
  logic [7:0] c;
  logic [3:0] r4, g4, b4;
  always_comb begin
    c  = INVERT ? ~bus.ram_do : bus.ram_do;
    r4 = {c[7:5], c[7]};
    g4 = {c[4:2], c[4]};
    b4 = {c[1:0], c[1:0]};
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.ram_a      <= '0;
      bus.ram_r_n    <= 1'b1;
      va             <= 1'b0;
      ha             <= 1'b0;
      vba            <= 1'b0;
      vb             <= 1'b0;
      hb             <= 1'b0;
      vbb            <= 1'b0;
      bus.red        <= '0;
      bus.green      <= '0;
      bus.blue       <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_hblank <= 1'b0;
      bus.out_vblank <= 1'b0;
    end else begin
      va          <= bus.pix_valid;
      bus.ram_r_n <= !(bus.pix_valid && !bus.hblank && !bus.vblank);
      if (bus.pix_valid) begin
        bus.ram_a <= bus.pix_index;
        ha        <= bus.hblank;
        vba       <= bus.vblank;
      end
      vb            <= va;
      hb            <= ha;
      vbb           <= vba;
      bus.out_valid <= vb;
      // ram_do is live in the same cycle as stage-B flags; bubbles leave the outputs untouched
      if (vb) begin
        bus.out_hblank                   <= hb;
        bus.out_vblank                   <= vbb;
        {bus.red, bus.green, bus.blue} <= (hb || vbb) ? 12'h000 : {r4, g4, b4};
      end
    end
  end
endmodule

// File: tb/tb_color_lookup.sv
// tb_color_lookup: directed checks of color_lookup (normal and inverted palette)
module tb_color_lookup;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  logic [7:0] mem [256];
  always #5 clk = ~clk;
  color_lookup_if bus ();
  color_lookup_if ibus ();
  color_lookup #(.INVERT(1'b0)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));
  color_lookup #(.INVERT(1'b1)) dut_inv (.clk(clk), .reset_n(reset_n), .bus(ibus.slave));
  assign ibus.pix_valid = bus.pix_valid;
  assign ibus.pix_index = bus.pix_index;
  assign ibus.hblank    = bus.hblank;
  assign ibus.vblank    = bus.vblank;
  // synchronous color RAM: reads return 0xFF when not enabled
  always @(posedge clk) begin
    bus.ram_do  <= !bus.ram_r_n ? mem[bus.ram_a] : 8'hFF;
    ibus.ram_do <= !ibus.ram_r_n ? mem[ibus.ram_a] : 8'hFF;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] idx, input logic h, input logic vbl);
    bus.pix_valid = v;
    bus.pix_index = idx;
    bus.hblank    = h;
    bus.vblank    = vbl;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [11:0] e;
    logic [11:0] ei;
    int j;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h12] = 8'hE9;
    reset_n = 1'b0;
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_ram_a", 32'(bus.ram_a), 32'h00);
    check("rst_ram_r_n", 32'(bus.ram_r_n), 32'h1);
    check("rst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h000);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_blanks", 32'({bus.out_hblank, bus.out_vblank}), 32'h0);
    reset_n = 1'b1;
    step(1'b1, 8'h12, 1'b0, 1'b0);
    check("px_ram_r_n", 32'(bus.ram_r_n), 32'h0);
    check("px_ram_a", 32'(bus.ram_a), 32'h12);
    step(1'b0, 8'h77, 1'b0, 1'b0);
    check("px_n2_valid", 32'(bus.out_valid), 32'h0);
    check("px_hold_ram_a", 32'(bus.ram_a), 32'h12);
    check("px_idle_ram_r_n", 32'(bus.ram_r_n), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("px_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hF45);
    check("px_valid", 32'(bus.out_valid), 32'h1);
    check("px_blanks", 32'({bus.out_hblank, bus.out_vblank}), 32'h0);
    check("inv_px_rgb", 32'({ibus.red, ibus.green, ibus.blue}), 32'h0BA);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("px_one_shot", 32'(bus.out_valid), 32'h0);
    check("px_rgb_held", 32'({bus.red, bus.green, bus.blue}), 32'hF45);
    for (int i = 0; i < 18; i++) begin
      step(i < 16, 8'(i), 1'b0, 1'b0);
      if (i < 2) check("stream_fill", 32'(bus.out_valid), 32'h0);
      else begin
        j  = i - 2;
        e  = {4'h0, 4'((j >> 2) * 2), 4'((j & 3) * 5)};
        ei = {4'hF, 4'(2 * (7 - (j >> 2)) + 1), 4'(5 * (3 - (j & 3)))};
        check("stream_valid", 32'(bus.out_valid), 32'h1);
        check("stream_rgb", 32'({bus.red, bus.green, bus.blue}), 32'(e));
        check("inv_stream_rgb", 32'({ibus.red, ibus.green, ibus.blue}), 32'(ei));
      end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("stream_end", 32'(bus.out_valid), 32'h0);
    step(1'b1, 8'hFF, 1'b1, 1'b0);
    check("hblank_ram_r_n", 32'(bus.ram_r_n), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("hblank_valid", 32'(bus.out_valid), 32'h1);
    check("hblank_flags", 32'({bus.out_hblank, bus.out_vblank}), 32'h2);
    check("hblank_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h000);
    check("inv_hblank_rgb", 32'({ibus.red, ibus.green, ibus.blue}), 32'h000);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    check("vblank_ram_r_n", 32'(bus.ram_r_n), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("vblank_valid", 32'(bus.out_valid), 32'h1);
    check("vblank_flags", 32'({bus.out_hblank, bus.out_vblank}), 32'h1);
    check("vblank_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h000);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("bub_ram_r_n", 32'(bus.ram_r_n), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("bub_valid", 32'(bus.out_valid), 32'h1);
    check("bub_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hFFF);
    check("bub_flags", 32'({bus.out_hblank, bus.out_vblank}), 32'h0);
    check("inv_bub_rgb", 32'({ibus.red, ibus.green, ibus.blue}), 32'h000);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("bub_hole_valid", 32'(bus.out_valid), 32'h0);
      check("bub_hold_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hFFF);
    end
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'h01, 1'b0, 1'b0);
    reset_n = 1'b0;
    step(1'b1, 8'h02, 1'b0, 1'b0);
    reset_n = 1'b1;
    check("mrst_ram_a", 32'(bus.ram_a), 32'h00);
    check("mrst_ram_r_n", 32'(bus.ram_r_n), 32'h1);
    check("mrst_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h000);
    check("mrst_valid", 32'(bus.out_valid), 32'h0);
    check("mrst_blanks", 32'({bus.out_hblank, bus.out_vblank}), 32'h0);
    check("inv_mrst_rgb", 32'({ibus.red, ibus.green, ibus.blue}), 32'h000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check("mrst_flushed", 32'(bus.out_valid), 32'h0);
    end
    step(1'b1, 8'h12, 1'b0, 1'b0);
    check("post_ram_r_n", 32'(bus.ram_r_n), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_n2_valid", 32'(bus.out_valid), 32'h0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_n3_valid", 32'(bus.out_valid), 32'h1);
    check("post_rgb", 32'({bus.red, bus.green, bus.blue}), 32'hF45);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/color_lookup.md
COLOR_LOOKUP -- requirements
Module: color_lookup

Interface
REQ-001 Parameter INVERT, default 0; when 1, the color byte read from color RAM SHALL be bitwise inverted before decode.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 pix_valid  input  1  pixel strobe; one pixel is presented per cycle in which it is high.
REQ-005 pix_index  input  8  priority-resolved color RAM address for the current pixel.
REQ-006 hblank  input  1  horizontal blanking, aligned with pix_valid/pix_index.
REQ-007 vblank  input  1  vertical blanking, aligned with pix_valid/pix_index.
REQ-008 ram_a  output  8  color RAM read address (video port).
REQ-009 ram_r_n  output  1  active-low read enable to color RAM video port.
REQ-010 ram_do  input  8  color RAM read data, valid the cycle after a cycle with ram_r_n low.
REQ-011 red  output  4  red intensity.
REQ-012 green  output  4  green intensity.
REQ-013 blue  output  4  blue intensity.
REQ-014 out_valid  output  1  high for exactly one cycle per accepted pixel.
REQ-015 out_hblank  output  1  hblank delayed to align with red/green/blue.
REQ-016 out_vblank  output  1  vblank delayed to align with red/green/blue.

Function
REQ-017 Stage A: on a cycle N with pix_valid high, the block SHALL register ram_a <= pix_index, a valid flag, and the blank flags.
REQ-018 Stage A read: ram_r_n SHALL be low in cycle N+1 only if pix_valid was high and hblank and vblank were both low in cycle N; otherwise ram_r_n SHALL be high.
REQ-019 ram_a SHALL hold its previous value when pix_valid is low.
REQ-020 Stage B: in cycle N+2, ram_do SHALL be captured together with the delayed valid and blank flags.
REQ-021 Stage C: red/green/blue/out_valid/out_hblank/out_vblank SHALL be registered so that a pixel accepted in cycle N appears in cycle N+3; fixed latency 3, no stalls, no backpressure.
REQ-022 Decode: with c = ram_do (or ~ram_do when INVERT=1), r3=c[7:5], g3=c[4:2], b2=c[1:0].
REQ-023 Expansion: red={r3,r3[2]}, green={g3,g3[2]}, blue={b2,b2}; 3'b111 SHALL give 4'hF, 3'b000 SHALL give 4'h0, 2'b10 SHALL give 4'hA.
REQ-024 Blanked pixel, i.e. hblank or vblank high at acceptance: the pixel SHALL emerge with out_valid high, the matching out_hblank/out_vblank, and red=green=blue=0 regardless of ram_do.
REQ-025 Bubble, i.e. pix_valid low in cycle N: out_valid SHALL be low in cycle N+3, and red/green/blue/out_hblank/out_vblank SHALL hold their previous values.
REQ-026 Back-to-back pixels with pix_valid high on every cycle SHALL produce one output per cycle, in order, with no loss or duplication.
REQ-027 The block SHALL NOT drive the CPU port of color RAM; CPU writes racing a video read return whichever data the RAM presents, with no retry.

Reset
REQ-028 While reset_n is low at a rising edge, the following SHALL be cleared on that edge: ram_a=0, ram_r_n=1, red=green=blue=0, out_valid=0, out_hblank=0, out_vblank=0, and all internal valid flags.
REQ-029 Reset asserted mid-stream SHALL discard every in-flight pixel; after release, the first out_valid SHALL occur exactly 3 cycles after the first accepted pixel.

Verification
REQ-030 Single pixel: reset released; pix_index=0x12, pix_valid=1 for one cycle, blanks low; ram_do=0xE9 in N+2 -> ram_r_n low in N+1 with ram_a=0x12; N+3: red=F, green=4, blue=5, out_valid=1 for one cycle.
REQ-031 Streaming: indices 0x00..0x0F on consecutive cycles, RAM model returns the address as data -> 16 consecutive out_valid cycles with decoded values in order.
REQ-032 Blanking: pixel with hblank=1, RAM model returns 0xFF -> ram_r_n stays high; N+3: out_valid=1, out_hblank=1, RGB=0.
REQ-033 Bubble hold: pixel 0xFF, then pix_valid=0 for 2 cycles -> RGB=F/F/F in N+3, out_valid low for the next 2 cycles, RGB held.
REQ-034 INVERT=1: ram_do=0x00 -> red=green=blue=F; ram_do=0xFF -> all 0.
REQ-035 Reset mid-flight: 3 pixels accepted, reset_n low for 1 cycle while they are in flight -> no out_valid pulses for those 3 pixels; all outputs 0 on the cycle after the reset edge.
